// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types and constants for the iterative multiply/divide unit
package muldiv_unit_pkg;
  typedef logic [31:0] basic_data_t;
  typedef logic [4:0] reg_addr_t;
  typedef logic [2:0] muldiv_code_t;
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_code_t MD_MUL = 3'd0;
  localparam muldiv_code_t MD_MULH = 3'd1;
  localparam muldiv_code_t MD_MULHSU = 3'd2;
  localparam muldiv_code_t MD_MULHU = 3'd3;
  localparam muldiv_code_t MD_DIV = 3'd4;
  localparam muldiv_code_t MD_DIVU = 3'd5;
  localparam muldiv_code_t MD_REM = 3'd6;
  localparam muldiv_code_t MD_REMU = 3'd7;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_CALC = 2'd1;
  localparam muldiv_state_t ST_FIXUP = 2'd2;
  localparam muldiv_state_t ST_DONE = 2'd3;
  localparam int MULDIV_ITER = 32;
endpackage

// File: rtl/muldiv_core_iter.sv
// muldiv_core_iter: radix-2 shift-add multiply / restoring shift-subtract divide datapath
module muldiv_core_iter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem
);
  logic [W-1:0] hi, lo, m;
  logic [W:0] sum, sh, diff;
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh = {hi, lo[W-1]};
    diff = sh - {1'b0, m};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      m <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      m <= b;
    end else if (step) begin
      if (is_div) begin
        hi <= diff[W] ? sh[W-1:0] : diff[W-1:0];
        lo <= {lo[W-2:0], ~diff[W]};
      end else begin
        {hi, lo} <= {sum, lo[W-1:1]};
      end
    end
  end
  assign prod = {hi, lo};
  assign quot = lo;
  assign rem = hi;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with flush and special-case short path
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  muldiv_code_t      code,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  reg_addr_t         rdAddrIn,
  input  logic              flush,
  output logic              busy,
  output logic              resultValid,
  output logic [DATA_W-1:0] result,
  output reg_addr_t         rdAddrOut
);
  localparam int CW = $clog2(ITER);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  muldiv_state_t state;
  logic [CW-1:0] count;
  muldiv_code_t code_q;
  reg_addr_t rd_q;
  logic neg_q;
  logic [DATA_W-1:0] result_q, mag1, mag2, spec_val, quot, rem, sel;
  logic [2*DATA_W-1:0] prod, prod_n;
  logic sn1, sn2, is_rem, div_zero, ovf, special, accept;
  always_comb begin
    sn1 = op1[DATA_W-1] && (code == MD_MULH || code == MD_MULHSU || code == MD_DIV || code == MD_REM);
    sn2 = op2[DATA_W-1] && (code == MD_MULH || code == MD_DIV || code == MD_REM);
    mag1 = sn1 ? -op1 : op1;
    mag2 = sn2 ? -op2 : op2;
    is_rem = code[2] && code[1];
    div_zero = code[2] && op2 == '0;
    ovf = (code == MD_DIV || code == MD_REM) && op1 == MIN_NEG && &op2;
    special = div_zero || ovf;
    spec_val = div_zero ? (is_rem ? op1 : '1) : (is_rem ? '0 : MIN_NEG);
    accept = state == ST_IDLE && req && !flush;
    prod_n = neg_q ? -prod : prod;
    sel = code_q == MD_MUL ? prod_n[DATA_W-1:0] :
          !code_q[2] ? prod_n[2*DATA_W-1:DATA_W] :
          code_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quot : quot);
  end
  muldiv_core_iter #(.W(DATA_W)) u_core (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .step(state == ST_CALC),
    .is_div(code_q[2]),
    .a(mag1),
    .b(mag2),
    .prod(prod),
    .quot(quot),
    .rem(rem)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      code_q <= MD_MUL;
      rd_q <= '0;
      neg_q <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (req) begin
        code_q <= code;
        rd_q <= rdAddrIn;
        neg_q <= is_rem ? sn1 : sn1 ^ sn2;
        count <= '0;
        state <= special ? ST_DONE : ST_CALC;
        if (special) result_q <= spec_val;
      end
    end else if (state == ST_CALC) begin
      count <= count + 1'b1;
      if (count == CW'(ITER - 1)) state <= ST_FIXUP;
    end else if (state == ST_FIXUP) begin
      result_q <= sel;
      state <= ST_DONE;
    end else begin
      state <= ST_IDLE;
    end
  end
  assign busy = state != ST_IDLE;
  assign resultValid = state == ST_DONE && !flush;
  assign result = result_q;
  assign rdAddrOut = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table plus scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic [2:0] code = 3'd0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [4:0] rdAddrIn = '0;
  logic flush = 1'b0;
  logic busy, resultValid;
  logic [31:0] result;
  logic [4:0] rdAddrOut;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0] res;
    logic [4:0] rd;
  } exp_t;
  exp_t sb[$];
  typedef struct {
    logic [2:0] code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] rd;
    logic [31:0] res;
    int lat;
  } vec_t;
  vec_t vecs[13];
  muldiv_unit dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .code(code),
    .op1(op1),
    .op2(op2),
    .rdAddrIn(rdAddrIn),
    .flush(flush),
    .busy(busy),
    .resultValid(resultValid),
    .result(result),
    .rdAddrOut(rdAddrOut)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && resultValid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_tag", 32'(rdAddrOut), 32'(e.rd));
      end
    end
  end
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    code = c;
    op1 = a;
    op2 = b;
    rdAddrIn = rd;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
  endtask
  task automatic wait_valid(input int exp_lat);
    int lat = 0;
    bit busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!busy) busy_ok = 1'b0;
    end while (!resultValid && lat < 200);
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_during", 32'(busy_ok), 32'd1);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
  endtask
  task automatic run_op(input vec_t v);
    exp_t e;
    issue(v.code, v.a, v.b, v.rd);
    e.res = v.res;
    e.rd = v.rd;
    sb.push_back(e);
    wait_valid(v.lat);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t v;
    vecs[0] = '{3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 34};
    vecs[1] = '{3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 34};
    vecs[2] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 34};
    vecs[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 34};
    vecs[4] = '{3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34};
    vecs[5] = '{3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34};
    vecs[6] = '{3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 34};
    vecs[7] = '{3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 34};
    vecs[8] = '{3'd5, 32'd7, 32'd0, 5'd9, 32'hFFFFFFFF, 1};
    vecs[9] = '{3'd7, 32'd7, 32'd0, 5'd10, 32'd7, 1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1};
    vecs[12] = '{3'd4, 32'd100, 32'hFFFFFFF9, 5'd13, 32'hFFFFFFF2, 34};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(resultValid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", 32'(rdAddrOut), 32'd0);
    for (int i = 0; i < 13; i++) run_op(vecs[i]);
    issue(3'd4, 32'd100, 32'd7, 5'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(busy), 32'd0);
    v = '{3'd5, 32'd1000, 32'd33, 5'd14, 32'd30, 34};
    run_op(v);
    issue(3'd5, 32'd7, 32'd0, 5'd15);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_valid", 32'(resultValid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 32'(busy), 32'd0);
    begin
      exp_t e;
      issue(3'd3, 32'h00010000, 32'h00010000, 5'd20);
      e.res = 32'd1;
      e.rd = 5'd20;
      sb.push_back(e);
      repeat (5) @(negedge clk);
      code = 3'd5;
      op1 = 32'd9;
      op2 = 32'd0;
      rdAddrIn = 5'd21;
      req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      wait_valid(29);
      repeat (3) begin
        @(negedge clk);
        check("ignored_req_idle", 32'(busy), 32'd0);
      end
    end
    issue(3'd0, 32'd12345, 32'd678, 5'd9);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resultValid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rdAddrOut), 32'd0);
    v = '{3'd0, 32'd12345, 32'd678, 5'd17, 32'd8369910, 34};
    run_op(v);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, sitting in the execute stage beside the ALU.
- Consumes a MulDivCode and two BasicData operands from decode/dispatch.
- Produces one 32-bit result with its destination register tag for writeback.
- Radix-2, one bit per cycle, 32 iterations; special divide cases take a short path.

Parameters:
- DATA_W, 32, operand/result width (equals DATA_WIDTH).
- ITER, 32, iteration count (equals DATA_W).

Ports:
- clk  in  1  core clock; one clock domain, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid; accepted only when busy=0 and flush=0.
- code  in  3  MulDivCode operation.
- op1  in  32  rs1 value (multiplicand/dividend).
- op2  in  32  rs2 value (multiplier/divisor).
- rdAddrIn  in  5  destination register tag, captured on accept.
- flush  in  1  pipeline flush; aborts any operation in progress.
- busy  out  1  high in every state except IDLE.
- resultValid  out  1  one-cycle pulse carrying the result.
- result  out  32  result; valid only while resultValid=1.
- rdAddrOut  out  5  captured tag; valid while resultValid=1.

Behaviour:
- States: IDLE, CALC, FIXUP, DONE.
- Reset: state=IDLE; busy=0, resultValid=0, result=0, rdAddrOut=0; counter and datapath registers cleared.
- Accept (state IDLE, req=1, flush=0):
  - Latch code and rdAddrIn.
  - Latch operand magnitudes: abs() applies to signed operands only, i.e. op1 for MULH, MULHSU, DIV and REM; op2 for MULH, DIV and REM.
  - Record the result-sign flag.
- Transitions from IDLE on accept:
  - Normal case -> CALC, count=0.
  - Special divide case -> DONE.
- Special divide cases (DIV/DIVU/REM/REMU):
  - Divisor 0: quotient=0xFFFFFFFF; remainder=op1.
  - Signed overflow (DIV/REM with op1=0x80000000, op2=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- CALC, one iteration per cycle; count increments; the edge with count=ITER-1 moves to FIXUP.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
- FIXUP (one cycle): apply two's-complement negation where the sign rule requires, then select the result.
  - MUL: low word of the product.
  - MULH, MULHSU, MULHU: high word of the product.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
  - Product sign = XOR of the signed operands' signs.
  - Quotient sign = sign(op1) XOR sign(op2), signed only.
  - Remainder sign follows the dividend.
  - Then -> DONE.
- DONE: resultValid=1 with result and rdAddrOut held stable; next edge -> IDLE.
- Latency, counting the accept edge as edge 0:
  - Normal case: DONE is entered at edge 33, so resultValid is seen in cycle 34.
  - Special case: DONE is entered at edge 0, so resultValid is seen in cycle 1.
- Back-to-back: busy=1 in DONE, so the earliest next accept is the cycle after DONE.
- req while busy=1: ignored, no queuing.
- flush in any state: state -> IDLE at the next edge; no resultValid pulse for the aborted operation.
  - flush during DONE suppresses the pulse: resultValid = (state==DONE) and not flush.
- req and flush high together in IDLE: not accepted.
- rst mid-operation: same as the reset values; the in-flight result is lost.
- Widths: all arithmetic on unsigned magnitudes (32-bit, product 64-bit); negation is modulo 2^32 or 2^64; no overflow flag.

Decomposition:
- BasicTypes package: add the MulDivState enum (IDLE, CALC, FIXUP, DONE) and the MULDIV_ITER constant.
- Reuse MulDivCode, BasicData and RegAddr from BasicTypes.
- One natural sub-module: muldiv_core_iter, the per-cycle shift-add / shift-subtract datapath (mode select, accumulator, quotient/remainder registers).
- Sign handling, special-case detection and the FSM stay in muldiv_unit.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, resultValid in cycle 34 after accept, busy high cycles 0..34.
- Each of the high-word variants:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with resultValid in cycle 1 after accept:
  - DIVU 7/0 -> 0xFFFFFFFF.
  - REMU 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Aborts and ignored requests:
  - flush in cycle 10 of a DIV -> IDLE next cycle, no resultValid ever; new req next cycle is accepted and completes correctly.
  - req pulsed while busy -> ignored.
- rst asserted in cycle 20 of a MUL -> all outputs 0 next cycle, busy=0; rdAddrOut tag 5'd17 is returned with a later completed op.
